// File: rtl/shot_arbiter_if.sv
// shot_arbiter_if: event, grant handshake and status bundle between oneshot sources, arbiter and consumer
interface shot_arbiter_if #(parameter int N = 4, parameter int IDW = 2);
  logic [N-1:0] shot_in;
  logic out_valid;
  logic [IDW-1:0] out_id;
  logic out_ready;
  logic [N-1:0] pending;
  logic [N-1:0] drop;
  logic drop_clr;
  modport master(output shot_in, out_ready, drop_clr, input out_valid, out_id, pending, drop);
  modport slave(input shot_in, out_ready, drop_clr, output out_valid, out_id, pending, drop);
endinterface

// File: rtl/shot_arbiter.sv
// shot_arbiter: latches oneshot pulses as pending requests and grants them round-robin over valid/ready
module shot_arbiter #(
  parameter int N = 4,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst,
  shot_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, ptr_n, id_n, sel;
  logic [N-1:0] acc, pend_n, drop_n;
  logic accept;
  assign accept = bus.out_valid & bus.out_ready;
  assign acc = accept ? N'(1) << bus.out_id : '0;
  assign pend_n = bus.shot_in | (bus.pending & ~acc);
  assign drop_n = (bus.drop & {N{~bus.drop_clr}}) | (bus.shot_in & bus.pending & ~acc);
  assign bus.out_valid = state == OFFER;
  // scan from the farthest candidate down so the one nearest ptr is written last
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.pending[(int'(ptr) + k) % N]) sel = IDW'((int'(ptr) + k) % N);
    end
  end
  always_comb begin
    state_n = state;
    id_n = bus.out_id;
    ptr_n = ptr;
    if (state == IDLE && |bus.pending) begin
      state_n = OFFER;
      id_n = sel;
    end
    if (state == OFFER && bus.out_ready) begin
      state_n = IDLE;
      ptr_n = (bus.out_id == IDW'(N - 1)) ? '0 : bus.out_id + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      bus.out_id <= '0;
      bus.pending <= '0;
      bus.drop <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      bus.out_id <= id_n;
      bus.pending <= pend_n;
      bus.drop <= drop_n;
    end
  end
endmodule

// File: tb/tb_shot_arbiter.sv
// tb_shot_arbiter: directed vector table plus hand sequences for reset behaviour
module tb_shot_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  shot_arbiter_if #(.N(N), .IDW(IDW)) bus ();
  shot_arbiter #(.N(N), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0] shot;
    logic rdy;
    logic clr;
    logic v;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] drop;
  } vec_t;
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  task automatic add(input logic [3:0] s, input logic r, input logic c, input logic v,
                     input logic [1:0] id, input logic [3:0] p, input logic [3:0] d);
    vec_t e;
    e.shot = s; e.rdy = r; e.clr = c; e.v = v; e.id = id; e.pend = p; e.drop = d;
    tbl.push_back(e);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] s, input logic r, input logic c);
    bus.shot_in = s;
    bus.out_ready = r;
    bus.drop_clr = c;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_state(input string tag, input logic v, input logic [1:0] id,
                              input logic [3:0] p, input logic [3:0] d);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) chk({tag, ".id"}, 32'(bus.out_id), 32'(id));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(p));
    chk({tag, ".drop"}, 32'(bus.drop), 32'(d));
  endtask
  initial begin
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b0);
    step;
    step;
    rst = 1'b0;
    drive(4'b0000, 1'b1, 1'b0);
    chk("reset.id", 32'(bus.out_id), 32'd0);
    expect_state("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    step;
    expect_state("reset+1", 1'b0, 2'd0, 4'b0000, 4'b0000);
    // simultaneous requests, ptr 0
    add(4'b1111, 1, 0, 0, 0, 4'b1111, 0);
    add(4'b0000, 1, 0, 1, 0, 4'b1111, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b1110, 0);
    add(4'b0000, 1, 0, 1, 1, 4'b1110, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b1100, 0);
    add(4'b0000, 1, 0, 1, 2, 4'b1100, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b1000, 0);
    add(4'b0000, 1, 0, 1, 3, 4'b1000, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    // single request src 2
    add(4'b0100, 1, 0, 0, 0, 4'b0100, 0);
    add(4'b0000, 1, 0, 1, 2, 4'b0100, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    // backpressure on src 3 with src 0 arriving mid-stall
    add(4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    add(4'b0000, 0, 0, 1, 3, 4'b1000, 0);
    add(4'b0001, 0, 0, 1, 3, 4'b1001, 0);
    add(4'b0000, 0, 0, 1, 3, 4'b1001, 0);
    add(4'b0000, 0, 0, 1, 3, 4'b1001, 0);
    add(4'b0000, 0, 0, 1, 3, 4'b1001, 0);
    add(4'b0000, 0, 0, 1, 3, 4'b1001, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0001, 0);
    add(4'b0000, 1, 0, 1, 0, 4'b0001, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    // overrun on src 1; set beats a simultaneous clear
    add(4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000);
    add(4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000);
    add(4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000);
    add(4'b0010, 0, 1, 1, 1, 4'b0010, 4'b0010);
    add(4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0010);
    add(4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0010);
    add(4'b0000, 0, 1, 1, 1, 4'b0010, 4'b0000);
    add(4'b0010, 1, 0, 0, 0, 4'b0010, 4'b0000);
    add(4'b0000, 1, 0, 1, 1, 4'b0010, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
    // move ptr to 3, then wrap fairness
    add(4'b0100, 1, 0, 0, 0, 4'b0100, 0);
    add(4'b0000, 1, 0, 1, 2, 4'b0100, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    add(4'b1001, 1, 0, 0, 0, 4'b1001, 0);
    add(4'b0000, 1, 0, 1, 3, 4'b1001, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0001, 0);
    add(4'b1010, 0, 0, 1, 0, 4'b1011, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b1010, 0);
    add(4'b0000, 1, 0, 1, 1, 4'b1010, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b1000, 0);
    add(4'b0000, 1, 0, 1, 3, 4'b1000, 0);
    add(4'b0000, 1, 0, 0, 0, 4'b0000, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].shot, tbl[i].rdy, tbl[i].clr);
      step;
      expect_state($sformatf("row%0d", i), tbl[i].v, tbl[i].id, tbl[i].pend, tbl[i].drop);
    end
    // reset mid-offer with a drop flagged, ptr left at 0 afterwards
    drive(4'b0001, 1'b0, 1'b0);
    step;
    drive(4'b0000, 1'b0, 1'b0);
    step;
    drive(4'b0001, 1'b0, 1'b0);
    step;
    expect_state("preoffer", 1'b1, 2'd0, 4'b0001, 4'b0001);
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b1);
    step;
    rst = 1'b0;
    drive(4'b1010, 1'b1, 1'b0);
    expect_state("rstoffer", 1'b0, 2'd0, 4'b0000, 4'b0000);
    step;
    drive(4'b0000, 1'b1, 1'b0);
    expect_state("postrst", 1'b0, 2'd0, 4'b1010, 4'b0000);
    step;
    expect_state("postrst.grant", 1'b1, 2'd1, 4'b1010, 4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shot_arbiter.md
# shot_arbiter

Round-robin arbiter that shares one downstream consumer among N button-event sources. Each source delivers single-cycle pulses from its own oneshot edge detector. The block latches each pulse as a pending request and grants pending requests one at a time over a valid/ready handshake. It sits between the bank of oneshot instances and the shared event consumer (counter, display update, etc.), and flags events lost to overrun.

## Interface
- N, 4, number of requesting sources (N ≥ 2, need not be a power of two)
- IDW, 2, width of grant ID; must equal ceil(log2(N))
- clk  input  1  clock; all logic on posedge clk
- rst  input  1  synchronous, active-high reset
- shot_in  input  N  per-source event pulses, one cycle wide, any number may be high at once
- out_valid  output  1  grant offered to consumer
- out_id  output  IDW  index of granted source; meaningful only while out_valid=1
- out_ready  input  1  consumer accepts the current grant
- pending  output  N  registered pending-request bits
- drop  output  N  sticky overrun flags, one per source
- drop_clr  input  1  clears all drop bits

## Operation
- Reset values: out_valid=0, out_id=0, pending=0, drop=0, rr pointer ptr=0, state IDLE.
- Accept event: a cycle with out_valid=1 and out_ready=1.
- pending[i] next value:
  - set if shot_in[i]=1;
  - else cleared if an accept of id i occurs this cycle;
  - else holds.
- Pulse and accept of the same source in the same cycle: pending[i] stays 1 (new event). No drop.
- drop[i] sets when shot_in[i]=1, pending[i]=1, and no accept of i occurs that cycle.
- drop_clr=1 clears all drop bits. A drop set in the same cycle wins for that bit.
- FSM, two states:
  - IDLE:
    - if pending≠0, select the first set bit searching ptr, ptr+1, …, N-1, 0, … (wrap mod N);
    - register its index into out_id, set out_valid=1, go to OFFER;
    - otherwise stay in IDLE with out_valid=0.
  - OFFER:
    - out_valid=1; out_id held stable until accept;
    - on accept: out_valid←0, ptr←(out_id+1) mod N, go to IDLE;
    - without accept: remain in OFFER, and no re-arbitration occurs even if higher-priority requests arrive.
- A granted source's pending bit remains 1 throughout OFFER and clears only on accept.
- Arbitration reads only the registered pending bits, never shot_in directly.

## Timing
- Latency: shot_in[i] high in cycle t → pending[i]=1 in t+1 → out_valid=1, out_id=i in t+2 (FSM idle, no competing requests).
- Accept in cycle t → pending[i]=0 and out_valid=0 in t+1. The next grant appears at t+2 at the earliest.
- Maximum throughput is one grant per 2 cycles.
- out_ready is ignored while out_valid=0.
- Reset mid-OFFER: the next cycle shows out_valid=0 and pending=0. Outstanding events are discarded and drop is not set.
- rst has priority over every input, including shot_in and drop_clr, in the same cycle.
- ptr wraps from N-1 to 0. It changes only on accept.

## Test plan
- Reset: hold rst=1 for 2 cycles with shot_in=4'b1111 and out_ready=1.
  - Required: in the cycle after rst falls, out_valid=0, pending=0, drop=0.
- Single request: shot_in=4'b0100 at cycle t, out_ready=1.
  - Required: out_valid=1, out_id=2 at t+2 only; pending[2]=0 at t+3.
- Simultaneous requests: shot_in=4'b1111 at t, ptr=0, out_ready=1.
  - Required: grants id 0,1,2,3 at t+2, t+4, t+6, t+8; pending=0 at t+9.
- Backpressure: request src 3, out_ready=0 for 5 cycles, then 1.
  - Required: out_id=3 is stable for all 6 offer cycles, and src 0 requesting during the stall does not preempt.
  - After accept, ptr=0 and src 0 is granted 2 cycles later.
- Overrun: out_ready=0 and shot_in[1] pulses at t and t+3.
  - Required: drop[1]=1 from t+4; pending[1]=1.
  - drop_clr at t+6 → drop[1]=0 at t+7.
  - Pulse at the accept cycle of src 1 → pending[1] stays 1 and drop[1] stays 0.
- Wrap fairness: ptr=3 with pending=4'b1001.
  - Required: grant 3, then 0.
  - Then, with src 3 re-requesting and src 1 pending, grant 1 before 3.
